lsu_rmw: RTL and testbench

- Load/store unit that sits directly upstream of the word-only data memory and feeds its write/address/data port.
- Accepts byte, halfword and word loads and stores from the core: RV32 LB/LH/LW/LBU/LHU/SB/SH/SW.
- Performs alignment checking, lane extraction and sign/zero extension.
- Implements sub-word stores as a read-modify-write sequence, because the memory writes whole words only.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_byte_lane.sv | 68 ++++++
 rtl/lsu_rmw.sv | 181 ++++++++++++++++++
 tb/tb_lsu_rmw.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the lsu_rmw load/store unit: RV32 funct3 codes,
// FSM state encoding and the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Flags illegal funct3 for the direction and sub-word misalignment.
   function automatic logic req_misaligned(input logic we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_LB:   bad = 1'b0;
         F3_LH:   bad = offset[0];
         F3_LW:   bad = (offset != 2'b00);
         F3_LBU:  bad = we;
         F3_LHU:  bad = we | offset[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic for lsu_rmw: load byte/halfword extraction with
// sign/zero extension, and sub-word merge of store data into an old word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rd_word,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select, extension and store merge.
   always_comb begin
      byte_s     = 8'h00;
      half_s     = 16'h0000;
      load_data  = 32'h0000_0000;
      store_word = rd_word;

      case (offset)
         2'd0:    byte_s = rd_word[7:0];
         2'd1:    byte_s = rd_word[15:8];
         2'd2:    byte_s = rd_word[23:16];
         2'd3:    byte_s = rd_word[31:24];
         default: byte_s = 8'h00;
      endcase

      if (offset[1]) begin
         half_s = rd_word[31:16];
      end else begin
         half_s = rd_word[15:0];
      end

      case (funct3)
         F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
         F3_LH:   load_data = {{16{half_s[15]}}, half_s};
         F3_LW:   load_data = rd_word;
         F3_LBU:  load_data = {24'h00_0000, byte_s};
         F3_LHU:  load_data = {16'h0000, half_s};
         default: load_data = 32'h0000_0000;
      endcase

      case (funct3)
         F3_SB: begin
            case (offset)
               2'd0:    store_word[7:0]   = wdata[7:0];
               2'd1:    store_word[15:8]  = wdata[7:0];
               2'd2:    store_word[23:16] = wdata[7:0];
               2'd3:    store_word[31:24] = wdata[7:0];
               default: store_word        = rd_word;
            endcase
         end
         F3_SH: begin
            if (offset[1]) begin
               store_word[31:16] = wdata;
            end else begin
               store_word[15:0] = wdata;
            end
         end
         default: store_word = rd_word;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data memory; sub-word stores use
// read-modify-write. Optional address range check: LSU_RANGE_CHECK_EN.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        dmem_mem_write,
   output logic [31:0] dmem_address,
   output logic [31:0] dmem_write_data,
   input  logic [31:0] dmem_read_data
);

`ifdef LSU_RANGE_CHECK_EN
   localparam logic RANGE_EN = 1'b1;
`else
   localparam logic RANGE_EN = 1'b0;
`endif
   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   state_t      state_r, state_nxt_s;
   logic        we_r;
   logic [2:0]  funct3_r;
   logic [1:0]  offset_r;
   logic [31:0] wdata_r;
   logic        capture_s;
   logic        range_err_s;

   logic        ready_r, ready_nxt_s;
   logic        mem_write_r, mem_write_nxt_s;
   logic [31:0] address_r, address_nxt_s;
   logic [31:0] write_data_r, write_data_nxt_s;
   logic        resp_valid_r, resp_valid_nxt_s;
   logic [31:0] resp_rdata_r, resp_rdata_nxt_s;
   logic        resp_err_r, resp_err_nxt_s;

   logic [31:0] load_data_s;
   logic [31:0] store_word_s;

   lsu_byte_lane u_lane (
      .funct3     (funct3_r),
      .offset     (offset_r),
      .rd_word    (dmem_read_data),
      .wdata      (wdata_r[15:0]),
      .load_data  (load_data_s),
      .store_word (store_word_s)
   );

   assign range_err_s = RANGE_EN & ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_nxt_s      = state_r;
      capture_s        = 1'b0;
      mem_write_nxt_s  = 1'b0;
      address_nxt_s    = address_r;
      write_data_nxt_s = write_data_r;
      resp_valid_nxt_s = 1'b0;
      resp_rdata_nxt_s = 32'h0000_0000;
      resp_err_nxt_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (req_valid) begin
               capture_s = 1'b1;
               if (req_misaligned(req_we, req_funct3, req_addr[1:0]) || range_err_s) begin
                  state_nxt_s      = RESP;
                  resp_valid_nxt_s = 1'b1;
                  resp_err_nxt_s   = 1'b1;
               end else begin
                  state_nxt_s   = ACCESS;
                  address_nxt_s = {req_addr[31:2], 2'b00};
                  if (req_we && (req_funct3 == F3_SW)) begin
                     mem_write_nxt_s  = 1'b1;
                     write_data_nxt_s = req_wdata;
                  end else begin
                     mem_write_nxt_s = 1'b0;
                  end
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            // Sub-word stores register the merged word so MERGE writes it whole.
            if (we_r) begin
               if (funct3_r == F3_SW) begin
                  state_nxt_s      = RESP;
                  resp_valid_nxt_s = 1'b1;
               end else begin
                  state_nxt_s      = MERGE;
                  mem_write_nxt_s  = 1'b1;
                  write_data_nxt_s = store_word_s;
               end
            end else begin
               state_nxt_s      = RESP;
               resp_valid_nxt_s = 1'b1;
               resp_rdata_nxt_s = load_data_s;
            end
         end
         MERGE: begin
            state_nxt_s      = RESP;
            resp_valid_nxt_s = 1'b1;
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      ready_nxt_s = (state_nxt_s == IDLE);
   end

   // Request capture and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_r         <= 1'b0;
         funct3_r     <= 3'd0;
         offset_r     <= 2'd0;
         wdata_r      <= 32'h0000_0000;
         ready_r      <= 1'b1;
         mem_write_r  <= 1'b0;
         address_r    <= 32'h0000_0000;
         write_data_r <= 32'h0000_0000;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         if (capture_s) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            offset_r <= req_addr[1:0];
            wdata_r  <= req_wdata;
         end else begin
            we_r     <= we_r;
            funct3_r <= funct3_r;
            offset_r <= offset_r;
            wdata_r  <= wdata_r;
         end
         ready_r      <= ready_nxt_s;
         mem_write_r  <= mem_write_nxt_s;
         address_r    <= address_nxt_s;
         write_data_r <= write_data_nxt_s;
         resp_valid_r <= resp_valid_nxt_s;
         resp_rdata_r <= resp_rdata_nxt_s;
         resp_err_r   <= resp_err_nxt_s;
      end
   end

   // A reset landing in a write cycle must not reach the memory.
   assign dmem_mem_write  = mem_write_r & ~rst;
   assign req_ready       = ready_r;
   assign dmem_address    = address_r;
   assign dmem_write_data = write_data_r;
   assign resp_valid      = resp_valid_r;
   assign resp_rdata      = resp_rdata_r;
   assign resp_err        = resp_err_r;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw with a behavioural word memory.
module tb_lsu_rmw;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        dmem_mem_write;
   logic [31:0] dmem_address, dmem_write_data, dmem_read_data;

   logic [31:0] mem [0:255];
   logic [31:0] snap [0:255];
   logic        fill, poke_en;
   logic [7:0]  poke_idx;
   logic [31:0] poke_data;

   int cyc = 0;
   int wr_count = 0;
   int wr_cyc = 0;
   int resp_seen = 0;
   int last_t = 0;
   int passed = 0;
   int total = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] t;
      logic [31:0] lat;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   lsu_rmw #(.MEM_WORDS(256)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dmem_mem_write(dmem_mem_write), .dmem_address(dmem_address),
      .dmem_write_data(dmem_write_data), .dmem_read_data(dmem_read_data)
   );

   assign dmem_read_data = (dmem_address[31:10] == 22'd0) ? mem[dmem_address[9:2]] : 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (poke_en) begin
         mem[poke_idx] <= poke_data;
      end
      if (dmem_mem_write) begin
         wr_count <= wr_count + 1;
         wr_cyc   <= cyc + 1;
         if (dmem_address[31:10] == 22'd0) mem[dmem_address[9:2]] <= dmem_write_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      total++;
      $display("FAIL %s: got no completion, expected completion within bound", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (dmem_mem_write) chk("wr_align", {30'd0, dmem_address[1:0]}, 32'd0);
         if (resp_valid) begin
            resp_seen++;
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
               e = q.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
               chk("latency", 32'(cyc - int'(e.t)), e.lat - 32'd1);
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat);
      exp_t e;
      int n;
      wait_ready();
      if (!req_ready) begin
         note_fail("ready_timeout");
         return;
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      last_t = cyc;
      e.rdata = er; e.err = ee; e.t = 32'(cyc); e.lat = 32'(lat);
      q.push_back(e);
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         note_fail("resp_timeout");
         q.delete();
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_idx = 8'(idx); poke_data = d;
      @(posedge clk);
      #1;
      poke_en = 1'b0;
   endtask

   initial begin
      int w0, r0, diffs;
      rst = 1'b1; fill = 1'b1; poke_en = 1'b0; poke_idx = 8'd0; poke_data = 32'd0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; fill = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata_err", {resp_rdata[30:0], resp_err}, 32'd0);
      chk("rst_mem_write", {31'd0, dmem_mem_write}, 32'd0);
      chk("rst_address", dmem_address, 32'd0);
      chk("rst_write_data", dmem_write_data, 32'd0);

      // Word round trip
      w0 = wr_count;
      do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      chk("sw_writes", 32'(wr_count - w0), 32'd1);
      chk("sw_mem", mem[4], 32'hDEADBEEF);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

      // Byte and halfword read-modify-write
      poke(4, 32'h11223344);
      for (int i = 0; i < 256; i++) snap[i] = mem[i];
      w0 = wr_count;
      do_req(1'b1, 3'd0, 32'h11, 32'hFFFFFFAB, 32'h0, 1'b0, 3);
      chk("sb_mem", mem[4], 32'h1122AB44);
      chk("sb_writes", 32'(wr_count - w0), 32'd1);
      chk("sb_write_time", 32'(wr_cyc - last_t), 32'd2);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (i != 4 && mem[i] !== snap[i]) diffs++;
      chk("sb_other_words", 32'(diffs), 32'd0);
      do_req(1'b1, 3'd1, 32'h12, 32'h1234CAFE, 32'h0, 1'b0, 3);
      chk("sh_mem", mem[4], 32'hCAFEAB44);

      // Sign and zero extension
      poke(8, 32'h80FF7F01);
      do_req(1'b0, 3'd0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      do_req(1'b0, 3'd4, 32'h23, 32'h0, 32'h00000080, 1'b0, 2);
      do_req(1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2);
      do_req(1'b0, 3'd5, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2);
      do_req(1'b0, 3'd0, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
      do_req(1'b0, 3'd4, 32'h21, 32'h0, 32'h0000007F, 1'b0, 2);
      do_req(1'b0, 3'd1, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2);

      // Misaligned and illegal requests
      w0 = wr_count;
      do_req(1'b0, 3'd2, 32'h6, 32'h0, 32'h0, 1'b1, 1);
      do_req(1'b1, 3'd1, 32'h3, 32'hFFFF, 32'h0, 1'b1, 1);
      do_req(1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1);
      do_req(1'b1, 3'd4, 32'h8, 32'h55, 32'h0, 1'b1, 1);
      do_req(1'b1, 3'd2, 32'h12, 32'h77, 32'h0, 1'b1, 1);
      chk("err_no_writes", 32'(wr_count - w0), 32'd0);

      // Reset during the MERGE cycle of a byte store
      poke(2, 32'h55667788);
      w0 = wr_count; r0 = resp_seen;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h9; req_wdata = 32'h0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      chk("rst_rmw_mem", mem[2], 32'h55667788);
      chk("rst_rmw_writes", 32'(wr_count - w0), 32'd0);
      chk("rst_rmw_no_resp", 32'(resp_seen - r0), 32'd0);

      // Out-of-range store
      w0 = wr_count;
`ifdef LSU_RANGE_CHECK_EN
      do_req(1'b1, 3'd2, 32'h400, 32'h12345678, 32'h0, 1'b1, 1);
      chk("range_writes", 32'(wr_count - w0), 32'd0);
`else
      do_req(1'b1, 3'd2, 32'h400, 32'h12345678, 32'h0, 1'b0, 2);
      chk("range_writes", 32'(wr_count - w0), 32'd1);
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
